// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-clock divider, h/v counters,
// sync decode and colour gating, with syncs and colour aligned one pixel tick late.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned RGB_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [RGB_W-1:0] rgb_in,
  output logic [10:0]      pixel_x,
  output logic [10:0]      pixel_y,
  output logic             video_on,
  output logic             pix_tick,
  output logic             frame_start,
  output logic             hsync,
  output logic             vsync,
  output logic [RGB_W-1:0] rgb_out
);

  localparam int unsigned CNT_W    = 11;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  // Low until the first tick after enable/reset; that tick issues (0,0) as a new frame.
  logic             started;

  logic             tick_c;
  logic             h_wrap_c;
  logic             v_wrap_c;
  logic [CNT_W-1:0] h_nxt_c;
  logic [CNT_W-1:0] v_nxt_c;
  logic             hs_act_c;
  logic             vs_act_c;

  assign pixel_x = h_cnt;
  assign pixel_y = v_cnt;

  // Next raster position and sync decode of the current (pre-advance) position.
  always_comb begin
    tick_c   = (div_cnt == DIV_W'(CLK_DIV - 1));
    h_wrap_c = (h_cnt == CNT_W'(H_TOTAL - 1));
    v_wrap_c = (v_cnt == CNT_W'(V_TOTAL - 1));
    h_nxt_c  = h_cnt;
    v_nxt_c  = v_cnt;
    if (started) begin
      if (h_wrap_c) begin
        h_nxt_c = '0;
        v_nxt_c = v_wrap_c ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_nxt_c = h_cnt + CNT_W'(1);
      end
    end
    hs_act_c = started && (h_cnt >= CNT_W'(HS_START)) && (h_cnt <= CNT_W'(HS_END));
    vs_act_c = started && (v_cnt >= CNT_W'(VS_START)) && (v_cnt <= CNT_W'(VS_END));
  end

  // Divider, raster counters and the one-tick-late output stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt     <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      started     <= 1'b0;
      video_on    <= 1'b0;
      pix_tick    <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= !HS_POL;
      vsync       <= !VS_POL;
      rgb_out     <= '0;
    end else if (!en) begin
      div_cnt     <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      started     <= 1'b0;
      video_on    <= 1'b0;
      pix_tick    <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= !HS_POL;
      vsync       <= !VS_POL;
      rgb_out     <= '0;
    end else begin
      pix_tick    <= tick_c;
      frame_start <= 1'b0;
      if (tick_c) begin
        div_cnt     <= '0;
        started     <= 1'b1;
        h_cnt       <= h_nxt_c;
        v_cnt       <= v_nxt_c;
        video_on    <= (h_nxt_c < CNT_W'(H_ACTIVE)) && (v_nxt_c < CNT_W'(V_ACTIVE));
        frame_start <= !started || (h_wrap_c && v_wrap_c);
        rgb_out     <= video_on ? rgb_in : '0;
        hsync       <= hs_act_c ? HS_POL : !HS_POL;
        vsync       <= vs_act_c ? VS_POL : !VS_POL;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances (divide-by-2 active-low, divide-by-1 active-high)
// checked every clock against a raster model computed from the count of enabled clock edges.
module tb_vga_timing_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic [2:0]  rgb_in;

  logic [10:0] a_x, a_y, b_x, b_y;
  logic        a_von, a_tick, a_fs, a_hs, a_vs;
  logic        b_von, b_tick, b_fs, b_hs, b_vs;
  logic [2:0]  a_rgb, b_rgb;

  int          vectors;
  int          miscompares;
  int          n;        // enabled clock edges since the last reset/disable
  logic [2:0]  rgb_sa;   // rgb_in captured at dut_a's most recent pixel tick
  logic [2:0]  rgb_sb;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(2), .RGB_W(3)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en), .rgb_in(rgb_in),
    .pixel_x(a_x), .pixel_y(a_y), .video_on(a_von), .pix_tick(a_tick),
    .frame_start(a_fs), .hsync(a_hs), .vsync(a_vs), .rgb_out(a_rgb)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .RGB_W(3)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .rgb_in(rgb_in),
    .pixel_x(b_x), .pixel_y(b_y), .video_on(b_von), .pix_tick(b_tick),
    .frame_start(b_fs), .hsync(b_hs), .vsync(b_vs), .rgb_out(b_rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs from raster geometry: tick k (k>=1) issues position k-1 in raster order;
  // syncs and colour reflect the position issued on the previous tick.
  task automatic check_set(input string pfx, input int div, input int ht, input int vt,
                           input int ha, input int va, input int hs0, input int hs1,
                           input int vs0, input int vs1, input bit hp, input bit vp,
                           input logic [2:0] rgb_s,
                           input logic [10:0] ox, input logic [10:0] oy, input logic ov,
                           input logic otk, input logic ofs, input logic ohs, input logic ovs,
                           input logic [2:0] orgb);
    int t, p, x, y, q, qx, qy;
    logic ev, etk, efs, ehs, evs;
    logic [2:0] ergb;
    t = n / div;
    etk = (n > 0) && (n % div == 0);
    p = 0; x = 0; y = 0; ev = 1'b0; efs = 1'b0; ehs = !hp; evs = !vp; ergb = 3'd0;
    if (t >= 1) begin
      p  = t - 1;
      x  = p % ht;
      y  = (p / ht) % vt;
      ev = (x < ha) && (y < va);
      efs = etk && (x == 0) && (y == 0);
    end
    if (t >= 2) begin
      q  = p - 1;
      qx = q % ht;
      qy = (q / ht) % vt;
      if (qx >= hs0 && qx <= hs1) ehs = hp;
      if (qy >= vs0 && qy <= vs1) evs = vp;
      if (qx < ha && qy < va) ergb = rgb_s;
    end
    check({pfx, "_pixel_x"},     32'(ox),   32'(x));
    check({pfx, "_pixel_y"},     32'(oy),   32'(y));
    check({pfx, "_video_on"},    32'(ov),   32'(ev));
    check({pfx, "_pix_tick"},    32'(otk),  32'(etk));
    check({pfx, "_frame_start"}, 32'(ofs),  32'(efs));
    check({pfx, "_hsync"},       32'(ohs),  32'(ehs));
    check({pfx, "_vsync"},       32'(ovs),  32'(evs));
    check({pfx, "_rgb_out"},     32'(orgb), 32'(ergb));
  endtask

  task automatic check_all();
    check_set("a", 2, 16, 8, 8, 4, 10, 12, 5, 6, 1'b0, 1'b0, rgb_sa,
              a_x, a_y, a_von, a_tick, a_fs, a_hs, a_vs, a_rgb);
    check_set("b", 1, 16, 8, 8, 4, 10, 12, 5, 6, 1'b1, 1'b1, rgb_sb,
              b_x, b_y, b_von, b_tick, b_fs, b_hs, b_vs, b_rgb);
  endtask

  // One clock: advance the model with the inputs present at the edge, then check.
  task automatic step();
    @(posedge clk);
    if (!rst || !en) begin
      n = 0;
    end else begin
      n++;
      if (n % 2 == 0) rgb_sa = rgb_in;
      rgb_sb = rgb_in;
    end
    #1;
    check_all();
  endtask

  task automatic async_reset_check();
    rst = 1'b0;
    n = 0;
    #1;
    check_all();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    n = 0;
    rgb_sa = 3'd0;
    rgb_sb = 3'd0;
    rst = 1'b0;
    en = 1'b0;
    rgb_in = 3'd0;

    #12;
    check_all();
    rst = 1'b1;
    en = 1'b1;

    // Constant colour over more than a full frame of dut_a.
    rgb_in = 3'b101;
    repeat (300) step();

    // Colour stepping per pixel, then fully random colour.
    for (int i = 0; i < 300; i++) begin
      step();
      rgb_in = 3'(i);
    end
    repeat (300) begin
      step();
      rgb_in = 3'($urandom);
    end

    // Drop enable mid-line at pixel_x==5.
    for (int i = 0; i < 64 && a_x != 11'd5; i++) step();
    check("reach_x5", 32'(a_x), 32'd5);
    en = 1'b0;
    repeat (4) step();
    en = 1'b1;
    repeat (40) step();

    // Random enable drops and asynchronous resets.
    repeat (1500) begin
      step();
      rgb_in = 3'($urandom);
      en = ($urandom_range(0, 199) != 0);
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 399) == 0) async_reset_check();
    end
    rst = 1'b1;
    en = 1'b1;

    // Directed mid-frame reset after a clean run.
    repeat (150) begin
      step();
      rgb_in = 3'($urandom);
    end
    async_reset_check();
    step();
    rst = 1'b1;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
